// File: rtl/crypto_input_arbiter.sv
// ---------------------------------------------------------------------------
// crypto_input_arbiter
//
// Packet-granular round-robin arbiter that shares the single crypto
// AXI4-Stream datapath between NUM_PORTS upstream RX queues. A port wins in
// IDLE and then owns the datapath until its tlast beat is accepted; the next
// decision starts searching at the port after the previous owner. One output
// register stage sits in front of the crypto slave. A 32-bit accepted-packet
// counter per port is exported flat for the read-only register bank.
//
// Handshake: a beat moves on any stream exactly on a rising clock edge where
// tvalid and tready are both 1. A master never changes tdata/tstrb/tuser/
// tlast while tvalid=1 and tready=0, and never drops tvalid without a
// transfer; tready may change freely.
//
// Ports:
//   axi_aclk, axi_areset    clock, asynchronous active-high reset
//   s_axis_*                NUM_PORTS packed slave streams (port i at slice i)
//   m_axis_*                registered master stream towards crypto
//   port_enable             1 = port may be granted at the next IDLE decision
//   clear_counters          level; holds every packet counter at 0
//   pkt_count               per-port counters, port i at [32i+31:32i]
//   grant_onehot            current owner; all-zero exactly when FSM is IDLE
// ---------------------------------------------------------------------------
module crypto_input_arbiter #(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int NUM_PORTS          = 4
) (
  input  logic                                        axi_aclk,
  input  logic                                        axi_areset,
  input  logic [NUM_PORTS*C_AXIS_DATA_WIDTH-1:0]      s_axis_tdata,
  input  logic [NUM_PORTS*(C_AXIS_DATA_WIDTH/8)-1:0]  s_axis_tstrb,
  input  logic [NUM_PORTS*C_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser,
  input  logic [NUM_PORTS-1:0]                        s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]                        s_axis_tlast,
  output logic [NUM_PORTS-1:0]                        s_axis_tready,
  output logic [C_AXIS_DATA_WIDTH-1:0]                m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]              m_axis_tstrb,
  output logic [C_AXIS_TUSER_WIDTH-1:0]               m_axis_tuser,
  output logic                                        m_axis_tvalid,
  output logic                                        m_axis_tlast,
  input  logic                                        m_axis_tready,
  input  logic [NUM_PORTS-1:0]                        port_enable,
  input  logic                                        clear_counters,
  output logic [NUM_PORTS*32-1:0]                     pkt_count,
  output logic [NUM_PORTS-1:0]                        grant_onehot
);

  localparam int STRB_W = C_AXIS_DATA_WIDTH / 8;
  localparam int IDX_W  = $clog2(NUM_PORTS);

  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0]     last_grant_q, last_grant_d;
  logic [NUM_PORTS-1:0] onehot_d;

  logic                 out_ready;
  logic [NUM_PORTS-1:0] cand;
  logic [IDX_W-1:0]     cand_idx;
  logic [IDX_W-1:0]     winner;
  logic                 win_found;

  logic [C_AXIS_DATA_WIDTH-1:0]  sel_data;
  logic [STRB_W-1:0]             sel_strb;
  logic [C_AXIS_TUSER_WIDTH-1:0] sel_user;
  logic                          sel_valid;
  logic                          sel_last;
  logic                          beat_accept;
  logic                          last_accept;

  // The output register can take a new beat when empty or draining this cycle.
  assign out_ready = m_axis_tready | ~m_axis_tvalid;
  assign cand      = s_axis_tvalid & port_enable;

  // Round-robin search: start one past the previous owner and wrap; the
  // first candidate found wins.
  always_comb begin : rr_search
    win_found = 1'b0;
    winner    = '0;
    cand_idx  = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      cand_idx = IDX_W'((int'(last_grant_q) + k) % NUM_PORTS);
      if (!win_found && cand[cand_idx]) begin
        win_found = 1'b1;
        winner    = cand_idx;
      end
    end
  end

  // Lane mux for the granted port.
  always_comb begin : lane_mux
    sel_data  = '0;
    sel_strb  = '0;
    sel_user  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_q == IDX_W'(i)) begin
        sel_data  = s_axis_tdata[i*C_AXIS_DATA_WIDTH +: C_AXIS_DATA_WIDTH];
        sel_strb  = s_axis_tstrb[i*STRB_W +: STRB_W];
        sel_user  = s_axis_tuser[i*C_AXIS_TUSER_WIDTH +: C_AXIS_TUSER_WIDTH];
        sel_valid = s_axis_tvalid[i];
        sel_last  = s_axis_tlast[i];
      end
    end
  end

  assign beat_accept = (state_q == PKT) && sel_valid && out_ready;
  assign last_accept = beat_accept && sel_last;

  // Only the owner sees ready, and only while in PKT.
  always_comb begin : ready_gen
    s_axis_tready = '0;
    if (state_q == PKT) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (grant_q == IDX_W'(i)) begin
          s_axis_tready[i] = out_ready;
        end
      end
    end
  end

  // Next-state logic. The grant is only re-evaluated in IDLE, so enable
  // changes and tvalid gaps on the owner never break a packet.
  always_comb begin : fsm_next
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    onehot_d     = grant_onehot;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d          = PKT;
          grant_d          = winner;
          onehot_d         = '0;
          onehot_d[winner] = 1'b1;
        end
      end
      PKT: begin
        if (last_accept) begin
          state_d      = IDLE;
          last_grant_d = grant_q;
          onehot_d     = '0;
        end
      end
      default: begin
        state_d  = IDLE;
        onehot_d = '0;
      end
    endcase
  end

  always_ff @(posedge axi_aclk or posedge axi_areset) begin : fsm_regs
    if (axi_areset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= IDX_W'(NUM_PORTS - 1);
      grant_onehot <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      grant_onehot <= onehot_d;
    end
  end

  // Output register stage: loads on every accepted beat, otherwise holds
  // until the downstream handshake empties it.
  always_ff @(posedge axi_aclk or posedge axi_areset) begin : out_regs
    if (axi_areset) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tstrb  <= '0;
      m_axis_tuser  <= '0;
    end else if (beat_accept) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tlast  <= sel_last;
      m_axis_tdata  <= sel_data;
      m_axis_tstrb  <= sel_strb;
      m_axis_tuser  <= sel_user;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

  // Per-port packet counters; clear has priority over a same-cycle increment.
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_cnt
    logic [31:0] cnt_q;

    always_ff @(posedge axi_aclk or posedge axi_areset) begin
      if (axi_areset) begin
        cnt_q <= '0;
      end else if (clear_counters) begin
        cnt_q <= '0;
      end else if (last_accept && (grant_q == IDX_W'(i))) begin
        cnt_q <= cnt_q + 32'd1;
      end
    end

    assign pkt_count[32*i +: 32] = cnt_q;
  end

endmodule
